// File: rtl/uart_rx_os_pkg.sv
// Shared state encoding, default parameters and width helper for the oversampling UART receiver.
package uart_rx_os_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    localparam int DEF_BAUD_DIV    = 1;
    localparam int DEF_OVERSAMPLE  = 16;
    localparam int DEF_DATA_BITS   = 7;
    localparam int DEF_SYNC_STAGES = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one tick every BAUD_DIV enabled clocks, restartable by clr.
module uart_baud_tick
    import uart_rx_os_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic clr,
    output logic tick
);

    localparam int W = cnt_w(BAUD_DIV);
    localparam logic [W-1:0] LAST = W'(BAUD_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ena) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = ena && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with valid/ready output register, framing/overrun reporting.
// Optional even parity bit enabled by defining UART_RX_OS_PARITY_EN.
module uart_rx_os
    import uart_rx_os_pkg::*;
#(
    parameter int BAUD_DIV    = DEF_BAUD_DIV,
    parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
    parameter int DATA_BITS   = DEF_DATA_BITS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic [1:0]           state_out
);

`ifdef UART_RX_OS_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int NBITS = DATA_BITS + PAR_BITS;
    localparam int OSW   = cnt_w(OVERSAMPLE);
    localparam int BCW   = cnt_w(NBITS + 1);
    localparam logic [OSW-1:0] OS_HALF  = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0] OS_FULL  = OSW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(NBITS - 1);
    localparam logic [BCW-1:0] PAR_IDX  = BCW'(DATA_BITS);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   tick;
    logic                   start_det;

    uart_rx_state_t         state;
    logic                   armed;
    logic                   stop_wait;
    logic [OSW-1:0]         os_cnt;
    logic [BCW-1:0]         bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_acc;
    logic                   done_p1;
    logic                   bad_stop_p1;
    logic                   bad_par_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs       = sync_q[SYNC_STAGES-1];
    assign start_det = ena && (state == IDLE) && armed && !rxs;
    assign state_out = state;

    uart_baud_tick #(
        .BAUD_DIV(BAUD_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .clr  (start_det),
        .tick (tick)
    );

    // Frame FSM: bit-centre sampling; the stop-sample result is handed to the output stage as *_p1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            armed       <= 1'b0;
            stop_wait   <= 1'b0;
            os_cnt      <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_acc     <= 1'b0;
            done_p1     <= 1'b0;
            bad_stop_p1 <= 1'b0;
            bad_par_p1  <= 1'b0;
        end else begin
            done_p1 <= 1'b0;
            if (ena) begin
                unique case (state)
                    IDLE: begin
                        if (rxs) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            state  <= START;
                            os_cnt <= '0;
                        end
                    end
                    START: if (tick) begin
                        if (os_cnt == OS_HALF) begin
                            os_cnt  <= '0;
                            bit_cnt <= '0;
                            par_acc <= 1'b0;
                            state   <= rxs ? IDLE : DATA;
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                    DATA: if (tick) begin
                        if (os_cnt == OS_FULL) begin
                            os_cnt  <= '0;
                            par_acc <= par_acc ^ rxs;
                            if (bit_cnt != PAR_IDX) begin
                                shreg <= DATA_BITS'({rxs, shreg} >> 1);
                            end
                            if (bit_cnt == BIT_LAST) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        // After a bad stop bit, wait for the line to return high and re-arm from IDLE.
                        if (stop_wait) begin
                            if (rxs) begin
                                stop_wait <= 1'b0;
                                armed     <= 1'b0;
                                state     <= IDLE;
                            end
                        end else if (tick) begin
                            if (os_cnt == OS_FULL) begin
                                os_cnt      <= '0;
                                done_p1     <= 1'b1;
                                bad_stop_p1 <= !rxs;
                                bad_par_p1  <= (PAR_BITS != 0) && par_acc;
                                if (rxs) begin
                                    state <= IDLE;
                                end else begin
                                    stop_wait <= 1'b1;
                                end
                            end else begin
                                os_cnt <= os_cnt + 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Output stage: delivery, handshake and registered error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            valid_out  <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= done_p1 && bad_stop_p1;
            parity_err <= done_p1 && bad_par_p1;
            overrun    <= 1'b0;
            if (done_p1 && !bad_stop_p1 && !bad_par_p1) begin
                if (!valid_out || ready_in) begin
                    data_out  <= shreg;
                    valid_out <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid_out && ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at default parameters (7 data bits, 16x oversample, BAUD_DIV 1).
module tb_uart_rx_os;

`ifdef UART_RX_OS_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int OS  = 16;
    localparam int LAT = 2 + 1 + OS / 2 + OS * (7 + 1 + PB);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       rx = 1'b1;
    logic       ready_in = 1'b1;
    logic [6:0] data_out;
    logic       valid_out;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic [1:0] state_out;

    int checks = 0;
    int failures = 0;
    int t_start = 0;
    int cyc = 0;

    uart_rx_os #(
        .BAUD_DIV   (1),
        .OVERSAMPLE (16),
        .DATA_BITS  (7),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .rx        (rx),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: counts and timestamps of output events, sampled on the falling edge.
    logic       vld_q = 1'b0;
    int         rise_cnt = 0, rise_cyc = 0, vld_hi = 0;
    int         ferr_cnt = 0, ferr_cyc = 0, perr_cnt = 0, ovr_cnt = 0, ovr_cyc = 0;
    logic [6:0] rise_data = '0;

    always @(negedge clk) begin
        vld_q <= valid_out;
        if (valid_out) vld_hi <= vld_hi + 1;
        if (valid_out && !vld_q) begin
            rise_cnt  <= rise_cnt + 1;
            rise_cyc  <= cyc;
            rise_data <= data_out;
        end
        if (frame_err) begin
            ferr_cnt <= ferr_cnt + 1;
            ferr_cyc <= cyc;
        end
        if (parity_err) perr_cnt <= perr_cnt + 1;
        if (overrun) begin
            ovr_cnt <= ovr_cnt + 1;
            ovr_cyc <= cyc;
        end
    end

    task automatic send_frame(input logic [6:0] d, input logic stop_b, input logic par_flip,
                              input int pause_at, input int abort_at);
        logic [15:0] bits;
        int nb;
        nb = 9 + PB;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 7; i++) bits[i+1] = d[i];
        if (PB != 0) bits[8] = (^d) ^ par_flip;
        bits[nb-1] = stop_b;
        for (int c = 0; c < nb * OS; c++) begin
            if (c == abort_at) break;
            if (c == pause_at) begin
                ena = 1'b0;
                repeat (50) @(negedge clk);
                ena = 1'b1;
            end
            @(negedge clk);
            rx = bits[c/OS];
            if (c == 0) t_start = cyc + 1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (data_out !== 7'h00) begin failures++; $display("FAIL reset_data got=%h want=00", data_out); end
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid_out); end
        checks++; if ({frame_err, parity_err, overrun} !== 3'b000) begin failures++; $display("FAIL reset_errs got=%b want=000", {frame_err, parity_err, overrun}); end
        checks++; if (state_out !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", state_out); end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_basic();
        int r0, v0, f0, p0, o0;
        r0 = rise_cnt; v0 = vld_hi; f0 = ferr_cnt; p0 = perr_cnt; o0 = ovr_cnt;
        ready_in = 1'b1;
        send_frame(7'h55, 1'b1, 1'b0, -1, -1);
        repeat (10) @(negedge clk);
        checks++; if (rise_cnt - r0 !== 1) begin failures++; $display("FAIL basic_rises got=%0d want=1", rise_cnt - r0); end
        checks++; if (rise_cyc !== t_start + LAT) begin failures++; $display("FAIL basic_latency got=%0d want=%0d", rise_cyc - t_start, LAT); end
        checks++; if (rise_data !== 7'h55) begin failures++; $display("FAIL basic_data got=%h want=55", rise_data); end
        checks++; if (vld_hi - v0 !== 1) begin failures++; $display("FAIL basic_valid_len got=%0d want=1", vld_hi - v0); end
        checks++; if ((ferr_cnt - f0) + (perr_cnt - p0) + (ovr_cnt - o0) !== 0) begin failures++; $display("FAIL basic_errs got=%0d want=0", (ferr_cnt - f0) + (perr_cnt - p0) + (ovr_cnt - o0)); end
    endtask

    task automatic test_glitch();
        int r0;
        r0 = rise_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (state_out !== 2'd1) begin failures++; $display("FAIL glitch_start got=%0d want=1", state_out); end
        rx = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (state_out !== 2'd0) begin failures++; $display("FAIL glitch_idle got=%0d want=0", state_out); end
        checks++; if (rise_cnt - r0 !== 0) begin failures++; $display("FAIL glitch_valid got=%0d want=0", rise_cnt - r0); end
    endtask

    task automatic test_frame_err();
        int r0, f0, tb;
        r0 = rise_cnt; f0 = ferr_cnt;
        send_frame(7'h33, 1'b0, 1'b0, -1, -1);
        tb = t_start;
        repeat (40) @(negedge clk);
        checks++; if (state_out !== 2'd3) begin failures++; $display("FAIL ferr_hold_state got=%0d want=3", state_out); end
        rx = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (ferr_cnt - f0 !== 1) begin failures++; $display("FAIL ferr_pulses got=%0d want=1", ferr_cnt - f0); end
        checks++; if (ferr_cyc !== tb + LAT) begin failures++; $display("FAIL ferr_timing got=%0d want=%0d", ferr_cyc - tb, LAT); end
        checks++; if (rise_cnt - r0 !== 0) begin failures++; $display("FAIL ferr_dropped got=%0d want=0", rise_cnt - r0); end
        send_frame(7'h2A, 1'b1, 1'b0, -1, -1);
        repeat (10) @(negedge clk);
        checks++; if (rise_cnt - r0 !== 1 || rise_data !== 7'h2A) begin failures++; $display("FAIL ferr_recover got=%0d/%h want=1/2a", rise_cnt - r0, rise_data); end
        checks++; if (ferr_cnt - f0 !== 1) begin failures++; $display("FAIL ferr_once got=%0d want=1", ferr_cnt - f0); end
    endtask

    task automatic test_back_to_back();
        int o0, tb;
        o0 = ovr_cnt;
        ready_in = 1'b0;
        send_frame(7'h11, 1'b1, 1'b0, -1, -1);
        send_frame(7'h22, 1'b1, 1'b0, -1, -1);
        tb = t_start;
        repeat (10) @(negedge clk);
        checks++; if (ovr_cnt - o0 !== 1) begin failures++; $display("FAIL b2b_overrun got=%0d want=1", ovr_cnt - o0); end
        checks++; if (ovr_cyc !== tb + LAT) begin failures++; $display("FAIL b2b_overrun_timing got=%0d want=%0d", ovr_cyc - tb, LAT); end
        checks++; if (data_out !== 7'h11 || valid_out !== 1'b1) begin failures++; $display("FAIL b2b_hold got=%h/%b want=11/1", data_out, valid_out); end
        ready_in = 1'b1;
        @(negedge clk);
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL b2b_consume got=%b want=0", valid_out); end
    endtask

    task automatic test_ena_freeze();
        int r0;
        r0 = rise_cnt;
        send_frame(7'h4B, 1'b1, 1'b0, 52, -1);
        repeat (10) @(negedge clk);
        checks++; if (rise_cnt - r0 !== 1) begin failures++; $display("FAIL ena_rises got=%0d want=1", rise_cnt - r0); end
        checks++; if (rise_cyc !== t_start + LAT + 50) begin failures++; $display("FAIL ena_latency got=%0d want=%0d", rise_cyc - t_start, LAT + 50); end
        checks++; if (rise_data !== 7'h4B) begin failures++; $display("FAIL ena_data got=%h want=4b", rise_data); end
    endtask

    task automatic test_reset_mid();
        int r0;
        send_frame(7'h5A, 1'b1, 1'b0, -1, 70);
        checks++; if (state_out !== 2'd2) begin failures++; $display("FAIL rstmid_pre_state got=%0d want=2", state_out); end
        rst_n = 1'b0;
        #1;
        checks++; if (state_out !== 2'd0 || data_out !== 7'h00 || valid_out !== 1'b0) begin failures++; $display("FAIL rstmid_outputs got=%0d/%h/%b want=0/00/0", state_out, data_out, valid_out); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rx = 1'b1;
        repeat (20) @(negedge clk);
        r0 = rise_cnt;
        send_frame(7'h6C, 1'b1, 1'b0, -1, -1);
        repeat (10) @(negedge clk);
        checks++; if (rise_cnt - r0 !== 1 || rise_data !== 7'h6C) begin failures++; $display("FAIL rstmid_next got=%0d/%h want=1/6c", rise_cnt - r0, rise_data); end
        checks++; if (rise_cyc !== t_start + LAT) begin failures++; $display("FAIL rstmid_latency got=%0d want=%0d", rise_cyc - t_start, LAT); end
    endtask

`ifdef UART_RX_OS_PARITY_EN
    task automatic test_parity();
        int r0, p0;
        r0 = rise_cnt; p0 = perr_cnt;
        send_frame(7'h07, 1'b1, 1'b1, -1, -1);
        repeat (10) @(negedge clk);
        checks++; if (perr_cnt - p0 !== 1) begin failures++; $display("FAIL par_bad_pulse got=%0d want=1", perr_cnt - p0); end
        checks++; if (rise_cnt - r0 !== 0) begin failures++; $display("FAIL par_bad_dropped got=%0d want=0", rise_cnt - r0); end
        send_frame(7'h07, 1'b1, 1'b0, -1, -1);
        repeat (10) @(negedge clk);
        checks++; if (rise_cnt - r0 !== 1 || rise_data !== 7'h07) begin failures++; $display("FAIL par_good got=%0d/%h want=1/07", rise_cnt - r0, rise_data); end
        checks++; if (perr_cnt - p0 !== 1) begin failures++; $display("FAIL par_good_noerr got=%0d want=1", perr_cnt - p0); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_ena_freeze();
        test_reset_mid();
`ifdef UART_RX_OS_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised oversampling UART receiver that replaces the fixed 7-bit receiver in front of the Hamming(7,4) decoder. It synchronises the asynchronous `rx` line, finds each bit centre with an OVERSAMPLE-tick counter, and checks the stop bit (and optional parity). Each received word is held in an output register with a valid/ready handshake, with framing-error and overrun reporting. It feeds `data_out` straight into the decoder's codeword input.

## Interface
- `BAUD_DIV`, 1: clk cycles per oversample tick (≥1).
- `OVERSAMPLE`, 16: ticks per bit; even, ≥4.
- `DATA_BITS`, 7: payload bits per frame (1..16).
- `SYNC_STAGES`, 2: rx synchroniser depth (≥2).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  freezes tick generator and FSM when low.
- `rx`  in  1  serial line, idle high, LSB first.
- `data_out`  out  DATA_BITS  received word; reset 0.
- `valid_out`  out  1  `data_out` holds an unconsumed word; reset 0.
- `ready_in`  in  1  consumer accepts the word this cycle.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit; reset 0.
- `parity_err`  out  1  one-cycle pulse on a parity mismatch; reset 0.
- `overrun`  out  1  one-cycle pulse when a word is dropped; reset 0.
- `state_out`  out  2  FSM state for debug; reset 0 (IDLE).

## Operation
- Synchroniser flops reset to 1. `rxs` is the last stage.
- Tick generator: counts 0..BAUD_DIV-1 and emits `tick` on wrap. It is cleared on entry to START.
- FSM states:
  - IDLE=0: enter START when `rxs`=0 and the `armed` flag is 1. `armed` sets whenever `rxs`=1 in IDLE.
  - START=1: at tick count OVERSAMPLE/2-1, sample `rxs`. If 1, it is a false start: go to IDLE. If 0, clear the counter and go to DATA.
  - DATA=2: sample every OVERSAMPLE ticks and shift right into the MSB. After DATA_BITS samples (DATA_BITS+1 with parity), go to STOP.
  - STOP=3: sample after OVERSAMPLE ticks.
    - Sample 1: frame is good; deliver the word; go to IDLE.
    - Sample 0: pulse `frame_err`; drop the word; stay in STOP until `rxs`=1; then go to IDLE with `armed` cleared.
- Delivery, in the cycle after the good stop sample:
  - Load `data_out` and set `valid_out` if `valid_out`=0, or if `ready_in`=1 in the same cycle (transfer and load at once; `valid_out` stays 1).
  - Otherwise pulse `overrun`, drop the new word and keep the old one.
- `valid_out` clears on `valid_out`&&`ready_in` with no simultaneous load. `data_out` is stable while `valid_out`=1.
- `ena`=0: tick counter, bit counter and FSM hold. The synchroniser and output handshake keep running.
- Asynchronous reset mid-frame: everything returns to reset values and the partial word is discarded.

## Timing
- Latency: `valid_out` rises N cycles after the edge at which the first synchroniser flop captures the start-bit 0.
  - N = SYNC_STAGES + 1 + BAUD_DIV·(OVERSAMPLE/2 + OVERSAMPLE·(DATA_BITS+P)).
  - P=1, or P=2 with parity.
  - Defaults: N = 2+1+8+128 = 139.
- Error pulses `frame_err`, `parity_err` and `overrun` are registered and assert in the same cycle `valid_out` would have risen.
- Back-to-back frames are accepted with zero idle bits. STOP exits at the stop-bit centre, so the next falling edge is seen in IDLE.

## Configuration
- `UART_RX_OS_PARITY_EN` defined:
  - An even-parity bit follows the data bits.
  - On mismatch: pulse `parity_err`, drop the word, then run the stop check normally.
  - A bad stop bit also asserts `frame_err`.
- Undefined: no parity bit, and `parity_err` is tied to 0.

## Structure
- Package `uart_rx_os_pkg` holds:
  - state enum `uart_rx_state_t` (IDLE, START, DATA, STOP);
  - default parameter constants;
  - width function `clog2`-based counter widths.
- Sub-module `uart_baud_tick`: BAUD_DIV divider with clear and enable, outputs `tick`.

## Test plan
- Defaults, send 7'h55 framed with a good stop and `ready_in`=1 → `valid_out`=1 for one cycle exactly 139 cycles after start, `data_out`=7'h55, no error pulses.
- 3-cycle low glitch on idle `rx` → FSM returns to IDLE via START, `valid_out` stays 0, `state_out` ends 0.
- Frame with stop bit 0, then line held low 40 cycles, then high, then a valid 7'h2A frame → `frame_err` pulses once; 7'h2A is delivered afterwards.
- `ready_in`=0, send 7'h11 then 7'h22 back-to-back → `overrun` pulses on the second frame; `data_out` stays 7'h11 until `ready_in`=1, then `valid_out` drops.
- `ena` low for 50 cycles mid-DATA → delivery is delayed by exactly 50 cycles and the data is correct. Separately, `rst_n` low mid-frame → all outputs 0, and the next full frame is received correctly.
- With `UART_RX_OS_PARITY_EN`, send 7'h07 with odd parity → `parity_err` pulse, no `valid_out`. The same word with correct parity → delivered.
